// File: rtl/word_sync_ff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : g15_timing_pkg
// Description : Drum timing constants, FSM state and pending-slot encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package g15_timing_pkg;

    localparam int BITS_PER_WORD = 29;
    localparam int WORDS_PER_REV = 108;

    typedef enum logic [1:0] {
        HALT     = 2'd0,
        RUN      = 2'd1,
        STEP     = 2'd2,
        STEP_BIT = 2'd3
    } timing_state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_SET  = 2'd1,
        PEND_CLR  = 2'd2
    } ff_pend_t;

endpackage
`default_nettype wire

// File: rtl/word_sync_ff_ctrl_slot.sv
`default_nettype none
// ============================================================================
// Module      : ff_req_slot
// Description : One pending set/clear slot; releases a one-clk s or r pulse on apply.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_req_slot
    import g15_timing_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic apply,
    input  logic set_req,
    input  logic clr_req,
    output logic ff_s,
    output logic ff_r,
    output logic conflict
);

    ff_pend_t r_pend;
    ff_pend_t w_pend_next;

    // Clear beats set; a request in the apply cycle itself is kept for the next word.
    always_comb begin
        w_pend_next = r_pend;
        if (clr_req) begin
            w_pend_next = PEND_CLR;
        end else if (set_req) begin
            w_pend_next = PEND_SET;
        end else if (apply) begin
            w_pend_next = PEND_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend   <= PEND_NONE;
            ff_s     <= 1'b0;
            ff_r     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            ff_s   <= apply && (r_pend == PEND_SET);
            ff_r   <= apply && (r_pend == PEND_CLR);
            if (set_req && clr_req) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_sync_ff_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : word_sync_ff_ctrl
// Description : Drum-timed scheduler applying FF set/reset requests at word end.
//               Optional single-bit stepping via macro WORD_SYNC_BIT_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module word_sync_ff_ctrl
    import g15_timing_pkg::*;
#(
    parameter int N_FF = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_req,
    input  logic            halt_req,
    input  logic            step_req,
`ifdef WORD_SYNC_BIT_STEP_EN
    input  logic            step_bit_req,
`endif
    input  logic [N_FF-1:0] set_req,
    input  logic [N_FF-1:0] clr_req,
    output logic [N_FF-1:0] ff_s,
    output logic [N_FF-1:0] ff_r,
    output logic [4:0]      bit_t,
    output logic [6:0]      word_t,
    output logic            t0,
    output logic            t28,
    output logic            running,
    output logic            conflict
);

    localparam logic [4:0] c_BIT_LAST  = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] c_WORD_LAST = 7'(WORDS_PER_REV - 1);

    timing_state_t   r_state;
    logic            r_halt_pend;
    logic            w_adv;
    logic            w_word_end;
    logic [N_FF-1:0] w_conflict;

    assign w_adv      = (r_state != HALT);
    assign w_word_end = w_adv && (bit_t == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= HALT;
            r_halt_pend <= 1'b0;
            bit_t       <= '0;
            word_t      <= '0;
        end else begin
            if (w_adv) begin
                if (bit_t == c_BIT_LAST) begin
                    bit_t  <= '0;
                    word_t <= (word_t == c_WORD_LAST) ? '0 : word_t + 7'd1;
                end else begin
                    bit_t <= bit_t + 5'd1;
                end
            end

            case (r_state)
                HALT: begin
                    r_halt_pend <= 1'b0;
                    if (run_req) begin
                        r_state <= RUN;
                    end else if (step_req) begin
                        r_state <= STEP;
`ifdef WORD_SYNC_BIT_STEP_EN
                    end else if (step_bit_req) begin
                        r_state <= STEP_BIT;
`endif
                    end
                end
                // A halt seen anywhere in the word (even with run_req) stops at word end.
                RUN: begin
                    if (halt_req || r_halt_pend) begin
                        if (w_word_end) begin
                            r_state     <= HALT;
                            r_halt_pend <= 1'b0;
                        end else begin
                            r_halt_pend <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (w_word_end) begin
                        r_state <= HALT;
                    end
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign t0      = (bit_t == 5'd0);
    assign t28     = (bit_t == c_BIT_LAST);
    assign running = (r_state != HALT);

    generate
        for (genvar gi = 0; gi < N_FF; gi++) begin : g_slot
            ff_req_slot u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .apply    (w_word_end),
                .set_req  (set_req[gi]),
                .clr_req  (clr_req[gi]),
                .ff_s     (ff_s[gi]),
                .ff_r     (ff_r[gi]),
                .conflict (w_conflict[gi])
            );
        end
    endgenerate

    assign conflict = |w_conflict;

endmodule
`default_nettype wire

// File: tb/tb_word_sync_ff_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_sync_ff_ctrl
// Description : Directed scenarios plus random stimulus against a position-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_sync_ff_ctrl;

    localparam int BPW = 29;
    localparam int WPR = 108;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_req = 1'b0;
    logic       halt_req = 1'b0;
    logic       step_req = 1'b0;
    logic [7:0] set_req = 8'h00;
    logic [7:0] clr_req = 8'h00;
    logic [7:0] ff_s;
    logic [7:0] ff_r;
    logic [4:0] bit_t;
    logic [6:0] word_t;
    logic       t0;
    logic       t28;
    logic       running;
    logic       conflict;

    int total = 0;
    int bad   = 0;

    // Reference model: absolute drum position plus a mode and per-FF pending action
    int         m_mode = 0;   // 0 halted, 1 running, 2 single word
    bit         m_seen = 0;
    int         m_pos  = 0;
    int         m_pend [8];
    logic [7:0] m_s = 8'h00;
    logic [7:0] m_r = 8'h00;
    bit         m_conf = 0;

    word_sync_ff_ctrl #(.N_FF(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_req  (run_req),
        .halt_req (halt_req),
        .step_req (step_req),
`ifdef WORD_SYNC_BIT_STEP_EN
        .step_bit_req (1'b0),
`endif
        .set_req  (set_req),
        .clr_req  (clr_req),
        .ff_s     (ff_s),
        .ff_r     (ff_r),
        .bit_t    (bit_t),
        .word_t   (word_t),
        .t0       (t0),
        .t28      (t28),
        .running  (running),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    task automatic model_next();
        bit adv;
        bit wend;
        if (!rst_n) begin
            m_mode = 0; m_seen = 0; m_pos = 0; m_conf = 0; m_s = '0; m_r = '0;
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            return;
        end
        adv  = (m_mode != 0);
        wend = adv && ((m_pos % BPW) == BPW - 1);
        for (int i = 0; i < 8; i++) begin
            m_s[i] = wend && (m_pend[i] == 1);
            m_r[i] = wend && (m_pend[i] == 2);
            if (clr_req[i])      m_pend[i] = 2;
            else if (set_req[i]) m_pend[i] = 1;
            else if (wend)       m_pend[i] = 0;
        end
        if ((set_req & clr_req) != 8'h00) m_conf = 1;
        case (m_mode)
            0: begin
                m_seen = 0;
                if (run_req)       m_mode = 1;
                else if (step_req) m_mode = 2;
            end
            1: begin
                if (halt_req || m_seen) begin
                    if (wend) begin m_mode = 0; m_seen = 0; end
                    else m_seen = 1;
                end
            end
            default: if (wend) m_mode = 0;
        endcase
        if (adv) m_pos = (m_pos + 1) % (BPW * WPR);
    endtask

    task automatic tick(input logic rn, input logic rr, input logic hr, input logic sr,
                        input logic [7:0] s, input logic [7:0] c);
        rst_n = rn; run_req = rr; halt_req = hr; step_req = sr; set_req = s; clr_req = c;
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_bit(input int b);
        int n = 0;
        while ((m_pos % BPW) != b && n < 200) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            n++;
        end
    endtask

    task automatic test_reset();
        bit fired = 0;
        tick(0, 0, 0, 0, 8'h00, 8'h00);
        tick(0, 0, 0, 0, 8'h00, 8'h00);
        total++; if (bit_t !== 5'd0) begin bad++; $display("FAIL reset_bit: got %0d want 0", bit_t); end
        total++; if (word_t !== 7'd0) begin bad++; $display("FAIL reset_word: got %0d want 0", word_t); end
        total++; if (running !== 1'b0 || t0 !== 1'b1 || t28 !== 1'b0)
            begin bad++; $display("FAIL reset_flags: running=%b t0=%b t28=%b want 0 1 0", running, t0, t28); end
        total++; if ((ff_s | ff_r) !== 8'h00 || conflict !== 1'b0)
            begin bad++; $display("FAIL reset_pulses: s=%h r=%h conflict=%b want 00 00 0", ff_s, ff_r, conflict); end
        tick(1, 1, 0, 0, 8'h00, 8'h00);
        goto_bit(12);
        tick(1, 0, 0, 0, 8'h04, 8'h00);
        tick(0, 0, 0, 0, 8'h00, 8'h00);
        total++; if (bit_t !== 5'd0 || word_t !== 7'd0 || running !== 1'b0 || ff_s !== 8'h00)
            begin bad++; $display("FAIL midword_reset: bit=%0d word=%0d running=%b s=%h want 0 0 0 00", bit_t, word_t, running, ff_s); end
        tick(1, 1, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 40; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (ff_s[2] === 1'b1) fired = 1;
        end
        total++; if (fired !== 1'b0) begin bad++; $display("FAIL cleared_slot_fired: got %b want 0", fired); end
    endtask

    task automatic test_set_pulse();
        int pulses = 0;
        int first_k = -1;
        int bit_at = -1;
        logic r_at = 1'b0;
        goto_bit(5);
        tick(1, 0, 0, 0, 8'h08, 8'h00);
        for (int k = 1; k <= 40; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (ff_s[3] === 1'b1) begin
                pulses++;
                if (first_k < 0) begin first_k = k; bit_at = int'(bit_t); r_at = ff_r[3]; end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL set_pulse_count: got %0d want 1", pulses); end
        total++; if (first_k != 23) begin bad++; $display("FAIL set_latency: got %0d want 23", first_k); end
        total++; if (bit_at != 0 || r_at !== 1'b0)
            begin bad++; $display("FAIL set_pulse_slot: bit=%0d r=%b want 0 0", bit_at, r_at); end
    endtask

    task automatic test_conflict();
        int rp = 0;
        bit sp = 0;
        goto_bit(7);
        tick(1, 0, 0, 0, 8'h02, 8'h02);
        total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conflict_set: got %b want 1", conflict); end
        for (int k = 0; k < 40; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (ff_r[1] === 1'b1) rp++;
            if (ff_s[1] === 1'b1) sp = 1;
        end
        total++; if (rp != 1 || sp != 0) begin bad++; $display("FAIL conflict_pulse: r_pulses=%0d s_seen=%0d want 1 0", rp, sp); end
        total++; if (conflict !== 1'b1) begin bad++; $display("FAIL conflict_sticky: got %b want 1", conflict); end
        tick(0, 0, 0, 0, 8'h00, 8'h00);
        total++; if (conflict !== 1'b0) begin bad++; $display("FAIL conflict_reset: got %b want 0", conflict); end
        tick(1, 1, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_word_end();
        int first_k = -1;
        goto_bit(28);
        tick(1, 0, 0, 0, 8'h10, 8'h00);
        total++; if (ff_s !== 8'h00) begin bad++; $display("FAIL wordend_no_pulse: got %h want 00", ff_s); end
        for (int k = 1; k <= 40 && first_k < 0; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (ff_s[4] === 1'b1) first_k = k;
        end
        total++; if (first_k != 29) begin bad++; $display("FAIL wordend_latency: got %0d want 29", first_k); end
    endtask

    task automatic test_step();
        int n = 0;
        int k;
        while (m_pos != 106 * BPW && n < 4000) begin tick(1, 0, 0, 0, 8'h00, 8'h00); n++; end
        tick(1, 0, 1, 0, 8'h00, 8'h00);
        n = 0;
        while (m_mode != 0 && n < 40) begin tick(1, 0, 0, 0, 8'h00, 8'h00); n++; end
        total++; if (running !== 1'b0 || word_t !== 7'd107 || bit_t !== 5'd0)
            begin bad++; $display("FAIL step_setup: running=%b word=%0d bit=%0d want 0 107 0", running, word_t, bit_t); end
        tick(1, 0, 0, 1, 8'h00, 8'h00);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL step_start: got %b want 1", running); end
        for (k = 1; k <= 40; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (running === 1'b0) break;
        end
        total++; if (k != 29 || word_t !== 7'd0 || bit_t !== 5'd0)
            begin bad++; $display("FAIL step_run: clk=%0d word=%0d bit=%0d want 29 0 0", k, word_t, bit_t); end
        for (int j = 0; j < 3; j++) tick(1, 0, 0, 0, 8'h00, 8'h00);
        total++; if (bit_t !== 5'd0 || running !== 1'b0)
            begin bad++; $display("FAIL step_hold: bit=%0d running=%b want 0 0", bit_t, running); end
    endtask

    task automatic test_halt_run();
        int k;
        logic run28 = 1'b0;
        tick(1, 1, 0, 0, 8'h00, 8'h00);
        goto_bit(10);
        tick(1, 1, 1, 0, 8'h00, 8'h00);
        for (k = 1; k <= 40; k++) begin
            tick(1, 0, 0, 0, 8'h00, 8'h00);
            if (bit_t === 5'd28) run28 = running;
            if (running === 1'b0) break;
        end
        total++; if (k != 18 || bit_t !== 5'd0 || run28 !== 1'b1)
            begin bad++; $display("FAIL halt_wins: clk=%0d bit=%0d run_at_28=%b want 18 0 1", k, bit_t, run28); end
    endtask

    task automatic test_random();
        logic [31:0] exp_v;
        logic [31:0] act_v;
        int errs = 0;
        for (int c = 0; c < 1500; c++) begin
            tick(($urandom % 200) != 0, ($urandom % 25) == 0, ($urandom % 20) == 0,
                 ($urandom % 25) == 0, 8'($urandom & $urandom & $urandom),
                 8'($urandom & $urandom & $urandom));
            exp_v = {m_s, m_r, 5'(m_pos % BPW), 7'(m_pos / BPW), (m_pos % BPW) == 0,
                     (m_pos % BPW) == BPW - 1, m_mode != 0, m_conf};
            act_v = {ff_s, ff_r, bit_t, word_t, t0, t28, running, conflict};
            total++;
            if (act_v !== exp_v || (ff_s & ff_r) !== 8'h00) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", c, act_v, exp_v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        test_reset();
        test_set_pulse();
        test_conflict();
        test_word_end();
        test_step();
        test_halt_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
